// File: rtl/reg_fifo_pkg.sv
// rtl/reg_fifo_pkg.sv - shared width helpers for the reg_fifo slice
package reg_fifo_pkg;

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_fifo_if.sv
// rtl/reg_fifo_if.sv - producer/consumer handshake bundle for reg_fifo
interface reg_fifo_if #(
    parameter int width = 32,
    parameter int depth = 4
);
    import reg_fifo_pkg::*;

    logic [width-1:0]          in;
    logic                      in_valid;
    logic                      in_ready;
    logic [width-1:0]          out;
    logic                      out_valid;
    logic                      out_ready;
    logic [cnt_w(depth)-1:0]   count;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, count
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, count
    );

endinterface

// File: rtl/reg_fifo_ptr.sv
// rtl/reg_fifo_ptr.sv - circular-buffer pointer that wraps from depth-1 to 0
module reg_fifo_ptr
    import reg_fifo_pkg::*;
#(
    parameter int depth = 4,
    parameter int pw    = ptr_w(depth)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv_i,
    output logic [pw-1:0] ptr_o
);

    logic [pw-1:0] ptr_q;
    logic [pw-1:0] ptr_d;

    // Explicit wrap so non-power-of-two depths never index past the last entry
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (ptr_q == pw'(depth - 1)) ? '0 : ptr_q + pw'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reg_fifo.sv
// rtl/reg_fifo.sv - depth-entry register FIFO with valid/ready on both sides; REG_FIFO_BYPASS_EN adds empty-FIFO bypass
module reg_fifo
    import reg_fifo_pkg::*;
#(
    parameter int               width = 32,
    parameter int               depth = 4,
    parameter logic [width-1:0] def   = '0
) (
    input  logic        clk,
    input  logic        reset,
    reg_fifo_if.slave   bus
);

    localparam int PW = ptr_w(depth);
    localparam int CW = cnt_w(depth);

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic             empty;
    logic             in_ready;
    logic             out_valid;
    logic [width-1:0] out_data;
    logic             push;
    logic             pop;

    assign empty    = (cnt_q == '0);
    assign in_ready = (cnt_q != CW'(depth));

`ifdef REG_FIFO_BYPASS_EN
    logic pass;

    // An empty FIFO with a ready consumer hands the word straight through untouched
    assign pass      = empty && bus.in_valid && bus.out_ready;
    assign out_valid = !empty || bus.in_valid;
    assign out_data  = !empty      ? mem_q[rd_ptr] :
                       bus.in_valid ? bus.in        : def;
    assign push      = bus.in_valid && in_ready && !pass;
    assign pop       = !empty && bus.out_ready;
`else
    assign out_valid = !empty;
    assign out_data  = out_valid ? mem_q[rd_ptr] : def;
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
`endif

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= bus.in;
        end
    end

    reg_fifo_ptr #(.depth(depth), .pw(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .adv_i (push),
        .ptr_o (wr_ptr)
    );

    reg_fifo_ptr #(.depth(depth), .pw(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .adv_i (pop),
        .ptr_o (rd_ptr)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out       = out_data;
    assign bus.count     = cnt_q;

endmodule
